dmem_arbiter_rmw: RTL and testbench

- Data-memory access controller between the single-cycle CPU and a word-wide synchronous data RAM with 1-cycle read latency.
- Arbitrates the RAM between the CPU load/store port and a debug/loader port using round-robin.
- Sequences sub-word CPU stores as read-modify-write, and stalls the CPU until each access completes.

---
 rtl/dmem_arbiter_rmw.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter_rmw.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_rmw.sv
// Data-memory controller: round-robin arbitration of one word-wide synchronous RAM between
// the CPU load/store port and a debug/loader port, with read-modify-write for sub-word stores.
module dmem_arbiter_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        stateDbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        RMW_WR = 2'd2,
        DBG_RD = 2'd3
    } state_t;

    state_t            state;
    logic              lastCpu;
    logic [ADDR_W-1:0] capAddr;
    logic              capHalf;
    logic [15:0]       capWdata;

    logic        grantCpu;
    logic        grantDbg;
    logic        cpuWord;
    logic [31:0] merged;

    assign cpuWord  = cpu_size[1];
    // On contention the requester that did not win last time goes first.
    assign grantCpu = (state == IDLE) && cpu_req && (!dbg_req || !lastCpu);
    assign grantDbg = (state == IDLE) && dbg_req && !grantCpu;
    assign stateDbg = state;

    always_comb begin
        merged = mem_rdata;
        if (capHalf) begin
            if (capAddr[1]) merged[31:16] = capWdata;
            else            merged[15:0]  = capWdata;
        end else begin
            merged[capAddr[1:0]*8 +: 8] = capWdata[7:0];
        end
    end

    // Everything is forced low while reset is held, even with requests pending.
    always_comb begin
        cpu_rdata  = '0;
        cpu_ack    = 1'b0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (grantCpu) begin
                        mem_en   = 1'b1;
                        mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
                        if (cpu_we && cpuWord) begin
                            mem_we    = 1'b1;
                            mem_wdata = cpu_wdata;
                            cpu_ack   = 1'b1;
                        end
                    end else if (grantDbg) begin
                        mem_en    = 1'b1;
                        mem_we    = dbg_we;
                        mem_addr  = {dbg_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata = dbg_we ? dbg_wdata : 32'd0;
                        dbg_gnt   = 1'b1;
                    end
                end
                CPU_RD: begin
                    mem_addr  = {capAddr[ADDR_W-1:2], 2'b00};
                    cpu_rdata = mem_rdata;
                    cpu_ack   = 1'b1;
                end
                RMW_WR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {capAddr[ADDR_W-1:2], 2'b00};
                    mem_wdata = merged;
                    cpu_ack   = 1'b1;
                end
                DBG_RD: begin
                    mem_addr   = {capAddr[ADDR_W-1:2], 2'b00};
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall = cpu_req && !cpu_ack && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lastCpu  <= 1'b0;
            capAddr  <= '0;
            capHalf  <= 1'b0;
            capWdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantCpu) begin
                        lastCpu  <= 1'b1;
                        capAddr  <= cpu_addr;
                        capHalf  <= cpu_size[0];
                        capWdata <= cpu_wdata[15:0];
                        if (!cpu_we)      state <= CPU_RD;
                        else if (!cpuWord) state <= RMW_WR;
                    end else if (grantDbg) begin
                        lastCpu <= 1'b0;
                        capAddr <= dbg_addr;
                        if (!dbg_we) state <= DBG_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter_rmw.sv
// Directed bench for dmem_arbiter_rmw: a behavioural 1-cycle RAM, driver tasks and a
// negedge monitor that checks RAM writes and read returns against expected queues.
module tb_dmem_arbiter_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  stateDbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];
    logic [63:0] expMemQ[$];
    logic [32:0] expCpuQ[$];
    logic [31:0] expDbgQ[$];
    logic [31:0] expOrderQ[$];
    logic        orderOn = 1'b0;

    dmem_arbiter_rmw #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stateDbg(stateDbg)
    );

    // clock
    always #5 clk = ~clk;

    // synchronous RAM model, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_en && mem_we) begin
                if (expMemQ.size() == 0) failNow("mem_write_unexpected");
                else check("mem_write", {mem_addr, mem_wdata}, expMemQ.pop_front());
            end
            if (cpu_ack) begin
                if (expCpuQ.size() == 0) failNow("cpu_ack_unexpected");
                else begin
                    logic [32:0] e;
                    e = expCpuQ.pop_front();
                    if (e[32]) check("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e[31:0]});
                end
            end
            if (dbg_rvalid) begin
                if (expDbgQ.size() == 0) failNow("dbg_rvalid_unexpected");
                else check("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, expDbgQ.pop_front()});
            end
            if (orderOn && mem_en) begin
                if (expOrderQ.size() == 0) failNow("grant_order_unexpected");
                else check("grant_order", {32'd0, mem_addr}, {32'd0, expOrderQ.pop_front()});
            end
        end
    end

    task automatic waitCpuAck(output int stalls);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) return;
            if (cpu_stall) stalls++;
        end
        failNow("cpu_ack_timeout");
        stalls = -1;
    endtask

    task automatic waitDbgGnt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg_gnt) return;
        end
        failNow("dbg_gnt_timeout");
    endtask

    task automatic cpuAccess(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int expStall);
        int stalls;
        @(posedge clk); #1;
        cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        waitCpuAck(stalls);
        check("cpu_stall_cycles", 64'(stalls), 64'(expStall));
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dbgAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        waitDbgGnt();
        @(posedge clk); #1;
        dbg_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            check("dbg_rvalid_timing", {63'd0, dbg_rvalid}, 64'd1);
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        check(name, {mem_en, mem_we, cpu_ack, cpu_stall, dbg_gnt, dbg_rvalid, stateDbg},
              8'd0);
    endtask

    initial begin
        int stalls;
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[8'h20 >> 2] = 32'h11223344;
        ram[8'h40 >> 2] = 32'hCAFEF00D;
        ram[8'h44 >> 2] = 32'h0BADF00D;
        ram[8'h50 >> 2] = 32'h11223344;
        ram[8'h80 >> 2] = 32'h13572468;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset_outputs");
        reset = 1'b1;
        @(negedge clk);
        checkIdleOutputs("idle_outputs");

        // word store: zero stall
        expMemQ.push_back({32'h10, 32'hDEADBEEF}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        // size 11 behaves as word; low address bits dropped
        expMemQ.push_back({32'h14, 32'h01020304}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b11, 32'h17, 32'h01020304, 0);
        // byte RMW at lane 2, then lane 3 with junk upper wdata bits
        expMemQ.push_back({32'h20, 32'h11AA3344}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b00, 32'h22, 32'h000000AA, 1);
        expMemQ.push_back({32'h20, 32'h77AA3344}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b00, 32'h23, 32'hFFFFFF77, 1);
        // half RMW: upper then lower lane (addr[0] ignored)
        ram[8'h30 >> 2] = 32'h11223344;
        expMemQ.push_back({32'h30, 32'hBEEF3344}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b01, 32'h32, 32'h0000BEEF, 1);
        ram[8'h30 >> 2] = 32'h11223344;
        expMemQ.push_back({32'h30, 32'h1122BEEF}); expCpuQ.push_back({1'b0, 32'd0});
        cpuAccess(1'b1, 2'b01, 32'h31, 32'h0000BEEF, 1);
        // load
        expCpuQ.push_back({1'b1, 32'hCAFEF00D});
        cpuAccess(1'b0, 2'b10, 32'h40, 32'd0, 1);
        // debug write then read back
        expMemQ.push_back({32'h60, 32'h12345678});
        dbgAccess(1'b1, 32'h62, 32'h12345678);
        expDbgQ.push_back(32'h12345678);
        dbgAccess(1'b0, 32'h60, 32'd0);
        check("ram_after_rmw", {32'd0, ram[8'h20 >> 2]}, {32'd0, 32'h77AA3344});

        // reset in RMW_WR: write must be abandoned
        @(posedge clk); #1;
        cpu_we = 1; cpu_size = 2'b00; cpu_addr = 32'h51; cpu_wdata = 32'h55; cpu_req = 1;
        @(posedge clk); #1;
        check("in_rmw_wr", {62'd0, stateDbg}, 64'd2);
        reset = 1'b0;
        #1;
        check("reset_drops_mem", {62'd0, mem_en, mem_we}, 64'd0);
        check("reset_state_idle", {62'd0, stateDbg}, 64'd0);
        cpu_req = 0;
        @(posedge clk); #1;
        check("ram_unchanged", {32'd0, ram[8'h50 >> 2]}, {32'd0, 32'h11223344});

        // contention held from reset: CPU first (last_cpu cleared), then alternate
        cpu_we = 0; cpu_size = 2'b10; cpu_addr = 32'h40; cpu_req = 1;
        dbg_we = 0; dbg_addr = 32'h80; dbg_req = 1;
        #1;
        checkIdleOutputs("reset_with_requests");
        expOrderQ = '{32'h40, 32'h80, 32'h44, 32'h84};
        expCpuQ.push_back({1'b1, 32'hCAFEF00D});
        expCpuQ.push_back({1'b1, 32'h0BADF00D});
        expDbgQ.push_back(32'h13572468);
        expMemQ.push_back({32'h84, 32'hA5A5A5A5});
        @(posedge clk); #1;
        reset = 1'b1;
        orderOn = 1'b1;
        fork
            begin
                int s;
                waitCpuAck(s);
                @(posedge clk); #1;
                cpu_addr = 32'h44;
                waitCpuAck(s);
                check("cpu_wait_behind_dbg", 64'(s), 64'd3);
                @(posedge clk); #1;
                cpu_req = 0;
            end
            begin
                waitDbgGnt();
                @(posedge clk); #1;
                dbg_we = 1; dbg_addr = 32'h84; dbg_wdata = 32'hA5A5A5A5;
                @(negedge clk);
                check("contention_rvalid", {63'd0, dbg_rvalid}, 64'd1);
                waitDbgGnt();
                @(posedge clk); #1;
                dbg_req = 0;
            end
        join
        repeat (2) @(negedge clk);
        orderOn = 1'b0;
        checkIdleOutputs("final_idle");
        check("queues_drained", {32'd0, 8'(expMemQ.size()), 8'(expCpuQ.size()),
              8'(expDbgQ.size()), 8'(expOrderQ.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
